alarm_beeper: RTL and testbench

ALARM_BEEPER -- requirements
Module: alarm_beeper

---
 rtl/egg_timer_pkg.sv | 18 +
 rtl/alarm_beeper_tick_gen.sv | 27 ++
 rtl/alarm_beeper.sv | 136 +++++++++++++
 tb/tb_alarm_beeper.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/egg_timer_pkg.sv
// Shared egg-timer constants: FSM encodings, default clock-derived timings, counter sizing.
package egg_timer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BEEP_ON  = 2'd1,
    BEEP_OFF = 2'd2
  } beep_state_e;

  localparam int TICK_DIV_DEFAULT  = 250000;
  localparam int TONE_HALF_DEFAULT = 25000;

  // Counters are at least one bit wide so degenerate parameters still elaborate.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alarm_beeper_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks; clear restarts the count.
module tick_gen
  import egg_timer_pkg::*;
#(
  parameter int DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = cnt_w(DIV);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == W'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) cnt_q <= '0;
    else                cnt_q <= cnt_d;
  end

endmodule

// File: rtl/alarm_beeper.sv
// Alarm beeper: BEEP_COUNT gated tone bursts after a trigger, cancellable, with a done pulse.
module alarm_beeper
  import egg_timer_pkg::*;
#(
  parameter int         TICK_DIV   = TICK_DIV_DEFAULT,
  parameter int         TONE_HALF  = TONE_HALF_DEFAULT,
  parameter int         ON_TICKS   = 80,
  parameter int         OFF_TICKS  = 80,
  parameter logic [3:0] BEEP_COUNT = 4'd3
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  input  logic cancel,
  output logic buzzer,
  output logic active,
  output logic done
);

  if (BEEP_COUNT == 4'd0) begin : g_bad_beep_count
    $error("alarm_beeper: BEEP_COUNT must be at least 1");
  end

  localparam int PH_W = cnt_w((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS);
  localparam int TN_W = cnt_w(TONE_HALF);

  beep_state_e     state_q, state_d;
  logic [3:0]      beeps_q, beeps_d;
  logic [PH_W-1:0] ticks_q, ticks_d;
  logic [TN_W-1:0] tone_cnt_q, tone_cnt_d;
  logic            tone_q, tone_d;
  logic            done_q, done_d;
  logic            clear;
  logic            tick;
  logic            phase_end;

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  always_comb begin
    phase_end = tick &&
                (((state_q == BEEP_ON)  && (ticks_q == PH_W'(ON_TICKS - 1))) ||
                 ((state_q == BEEP_OFF) && (ticks_q == PH_W'(OFF_TICKS - 1))));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      beeps_q    <= '0;
      ticks_q    <= '0;
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beeps_q    <= beeps_d;
      ticks_q    <= ticks_d;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      done_q     <= done_d;
    end
  end

  // Cancel outranks trigger; every state change or restart clears the timing counters.
  always_comb begin
    state_d = state_q;
    beeps_d = beeps_q;
    clear   = 1'b0;
    done_d  = 1'b0;
    if (cancel) begin
      if (state_q != IDLE) begin
        state_d = IDLE;
        clear   = 1'b1;
      end
    end else if (trigger) begin
      state_d = BEEP_ON;
      beeps_d = BEEP_COUNT;
      clear   = 1'b1;
    end else begin
      case (state_q)
        BEEP_ON: begin
          if (phase_end) begin
            clear = 1'b1;
            if (beeps_q == 4'd1) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = BEEP_OFF;
              beeps_d = beeps_q - 4'd1;
            end
          end
        end
        BEEP_OFF: begin
          if (phase_end) begin
            state_d = BEEP_ON;
            clear   = 1'b1;
          end
        end
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ticks_d    = ticks_q;
    tone_cnt_d = tone_cnt_q;
    tone_d     = tone_q;
    if (clear) begin
      ticks_d    = '0;
      tone_cnt_d = '0;
      tone_d     = (state_d == BEEP_ON);
    end else begin
      if (tick && (state_q != IDLE)) ticks_d = ticks_q + PH_W'(1);
      if (state_q == BEEP_ON) begin
        if (tone_cnt_q == TN_W'(TONE_HALF - 1)) begin
          tone_cnt_d = '0;
          tone_d     = ~tone_q;
        end else begin
          tone_cnt_d = tone_cnt_q + TN_W'(1);
        end
      end
    end
  end

  always_comb begin
    active = (state_q != IDLE);
    buzzer = (state_q == BEEP_ON) && tone_q;
    done   = done_q;
  end

endmodule

// File: tb/tb_alarm_beeper.sv
// Randomised and directed stimulus against a timeline model of the beep sequence; per-cycle scoreboard.
module tb_alarm_beeper;

  localparam int TD    = 4;
  localparam int TH    = 2;
  localparam int ONT   = 3;
  localparam int OFFT  = 2;
  localparam int BC    = 2;
  localparam int ON_C  = ONT * TD;
  localparam int OFF_C = OFFT * TD;
  localparam int SEQ   = BC * ON_C + (BC - 1) * OFF_C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic trigger = 1'b0;
  logic cancel = 1'b0;
  logic buzzer, active, done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  alarm_beeper #(
    .TICK_DIV   (TD),
    .TONE_HALF  (TH),
    .ON_TICKS   (ONT),
    .OFF_TICKS  (OFFT),
    .BEEP_COUNT (4'(BC))
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .trigger (trigger),
    .cancel  (cancel),
    .buzzer  (buzzer),
    .active  (active),
    .done    (done)
  );

  // t counts cycles since the triggering edge: t=1..SEQ is the running sequence.
  function automatic bit model_buzzer(input bit run, input int t);
    int p;
    if (!run) return 1'b0;
    p = (t - 1) % (ON_C + OFF_C);
    return (p < ON_C) && (((p / TH) % 2) == 0);
  endfunction

  bit m_run = 1'b0;
  int m_t = 0;
  bit m_done = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
    m_done = 1'b0;
    if (reset || cancel) begin
      m_run = 1'b0;
    end else if (trigger) begin
      m_run = 1'b1;
      m_t   = 1;
    end else if (m_run) begin
      m_t++;
      if (m_t > SEQ) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end
    exp_q.push_back({model_buzzer(m_run, m_t), m_run, m_done});
  end

  initial forever begin
    logic [2:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({buzzer, active, done} !== e) begin
        bad++;
        $display("FAIL outputs cyc=%0d got buzzer/active/done=%b required=%b", cyc, {buzzer, active, done}, e);
      end
    end
  end

  task automatic check_outputs(input logic [2:0] e, input string what);
    total++;
    if ({buzzer, active, done} !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got buzzer/active/done=%b required=%b", what, cyc, {buzzer, active, done}, e);
    end
  endtask

  task automatic drive(input bit tr, input bit ca, input bit rs);
    trigger = tr;
    cancel  = ca;
    reset   = rs;
    @(negedge clk);
    trigger = 1'b0;
    cancel  = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    idle(3);
    check_outputs(3'b000, "reset state");
    reset = 1'b0;
    idle(2);

    // natural run
    drive(1, 0, 0); idle(40);
    check_outputs(3'b000, "expired wait");
    // cancel at k+15
    drive(1, 0, 0); idle(14); drive(0, 1, 0); idle(40);
    // retrigger at k+25
    drive(1, 0, 0); idle(24); drive(1, 0, 0); idle(45);
    // trigger+cancel in IDLE, then mid-sequence at k+5
    drive(1, 1, 0); idle(5);
    drive(1, 0, 0); idle(4); drive(1, 1, 0); idle(40);
    // reset at k+8, then a full sequence
    drive(1, 0, 0); idle(7); drive(0, 0, 1);
    check_outputs(3'b000, "mid-sequence reset");
    idle(5);
    drive(1, 0, 0); idle(40);
    check_outputs(3'b000, "expired wait after reset");
    // cancel in IDLE, and a trigger on the done cycle
    drive(0, 1, 0); idle(3);
    drive(1, 0, 0); idle(SEQ); drive(1, 0, 0); idle(40);

    for (int i = 0; i < 3000; i++) begin
      trigger = ($urandom_range(0, 99) < 2);
      cancel  = ($urandom_range(0, 149) < 1);
      reset   = ($urandom_range(0, 299) < 1);
      @(negedge clk);
    end
    trigger = 1'b0;
    cancel  = 1'b0;
    reset   = 1'b0;
    idle(40);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
